openddr_dfi_data_sched: RTL and testbench
=========================================

# openddr_dfi_data_sched

DFI data-timing scheduler sitting between the command scheduler and the DFI datapath. It accepts column read/write commands, reserves data-bus slots at the programmed PHY latencies, and sequences write beats into the datapath. For reads it drives `dfi_rddata_en`, tracks outstanding read IDs in order, and returns tagged read data. Missing read returns are closed by a timeout error response.

## Interface

- `DATA_WIDTH`, 64: data beat width.
- `ID_WIDTH`, 4: command ID width.
- `MAX_LAT`, 31: largest supported latency in cycles. Latency config fields are 5 bits wide.
- `BURST_CYCLES`, 2: controller cycles occupied by one burst.
- `RD_DEPTH`, 8: maximum number of outstanding reads. Must be a power of 2.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: column command offered.
- `cmd_ready` out 1: command accepted this cycle.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_id` in ID_WIDTH: command tag.
- `cfg_wrlat` in 5: write-data latency (tphy_wrlat). Value 0 is treated as 1.
- `cfg_rdlat` in 5: read-enable latency (trddata_en). Value 0 is treated as 1.
- `cfg_rd_timeout` in 8: read-return timeout in cycles. 0 disables the timeout.
- `wbuf_valid` in 1: write data available.
- `wbuf_ready` out 1: write beat consumed this cycle.
- `wbuf_data` in DATA_WIDTH: write beat data.
- `wbuf_strb` in DATA_WIDTH/8: write beat strobes.
- `dp_wdata` out DATA_WIDTH: datapath write data.
- `dp_wstrb` out DATA_WIDTH/8: datapath write strobes. All zero means no beat.
- `dfi_rddata_en` out 1: read-data enable to the PHY.
- `rd_valid_any` in 1: OR of all phase `dfi_rddata_valid` bits.
- `dp_rdata` in DATA_WIDTH: registered read data from the datapath.
- `rsp_valid` out 1: read response beat.
- `rsp_id` out ID_WIDTH: tag of the response.
- `rsp_data` out DATA_WIDTH: response data.
- `rsp_last` out 1: final beat of a burst.
- `rsp_error` out 1: response was produced by a timeout.
- `busy` out 1: slot map non-empty or read FIFO non-empty.
- `err_underrun` out 1: sticky flag, write data was missing in a reserved slot.
- `err_spurious` out 1: sticky flag, read valid arrived with no read outstanding.

## Operation

- **Slot maps.** Two shift registers, `wr_map` and `rd_map`, each MAX_LAT+BURST_CYCLES bits wide. Bit k means "active k cycles from now". Both shift down by one every cycle.
- **Latency clamp.** Effective latency L = clamp(cfg, 1, MAX_LAT).
- **Accept rule.** A command is accepted when `cmd_valid && cmd_ready`.
  - `cmd_ready` is combinational.
  - It is 1 iff bits [L .. L+BURST_CYCLES-1] are free in both maps.
  - For a read, the read-ID FIFO must also be non-full.
  - Write and read bursts never overlap.
- **Accepting a write** sets `wr_map` bits [Lw .. Lw+BURST_CYCLES-1].
- **Accepting a read** sets `rd_map` bits [Lr .. Lr+BURST_CYCLES-1] and pushes `cmd_id` into the read-ID FIFO.
- **Write slot active** (post-shift bit 0 set):
  - `wbuf_ready` = 1.
  - If `wbuf_valid`: `dp_wdata`/`dp_wstrb` = `wbuf_data`/`wbuf_strb`, combinationally.
  - Otherwise: `dp_wdata` = 0, `dp_wstrb` = 0, the beat is dropped, and `err_underrun` is set.
- **Outside write slots:** `dp_wdata` = 0, `dp_wstrb` = 0, `wbuf_ready` = 0. This keeps the datapath write-enable low.
- **`dfi_rddata_en`** is registered and equals `rd_map` bit 0.
- **Read return.**
  - A beat counter (0..BURST_CYCLES-1) counts `rd_valid_any` cycles while the FIFO is non-empty.
  - One cycle after each valid, `rsp_valid` = 1 with `rsp_data` = `dp_rdata` and `rsp_id` = FIFO head.
  - On the final beat `rsp_last` = 1, the head is popped and the counter is cleared.
- **Timeout.**
  - A timer counts cycles while the FIFO is non-empty and `rd_valid_any` = 0. It clears on each valid and on each pop.
  - When the timer equals a non-zero `cfg_rd_timeout`: emit `rsp_valid`=1, `rsp_error`=1, `rsp_last`=1, `rsp_data`=0 with the head ID. Then pop the head and clear the beat counter.
  - If a valid arrives in the same cycle as the timeout, the valid wins.
- **Spurious valid.** `rd_valid_any` with an empty FIFO is ignored and sets `err_spurious`.
- **FIFO boundaries.**
  - A push and a pop in the same cycle are both performed.
  - When the FIFO is full, reads are blocked; writes can still be accepted.
- **Reset** is honoured mid-operation: maps, FIFO, counters and flags clear immediately and pending bursts are abandoned.

## Timing

- Write accepted at cycle t: beat j appears on `dp_*`/`wbuf_ready` in cycle t+Lw+j.
- Read accepted at cycle t: `dfi_rddata_en` is high in cycles t+Lr+j.
- Read response: `rsp_*` lags `rd_valid_any` by exactly 1 cycle.
- `cmd_ready` throughput: back-to-back same-type commands are accepted every BURST_CYCLES cycles.
- Config changes are applied only to newly accepted commands.
- Reset values of outputs:
  - 0: `wbuf_ready`, `dp_wdata`, `dp_wstrb`, `dfi_rddata_en`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_last`, `rsp_error`, `busy`, `err_underrun`, `err_spurious`.
  - 1: `cmd_ready`, when `cmd_valid` is asserted.

## Test plan

- **Single write.** Write with cfg_wrlat=5, BURST_CYCLES=2, `wbuf_valid` held high and strb=0xFF, accepted at t=10 → `wbuf_ready`=1 and `dp_wstrb`=0xFF at t=15 and t=16, 0 elsewhere.
- **Single read.** Read with id=3, cfg_rdlat=4, accepted at t=0; PHY returns valid at t=9 and t=10 → `dfi_rddata_en` high at t=4–5; `rsp_valid` at t=10 and t=11 with id=3; `rsp_last` only at t=11.
- **Conflict.** Write with Lw=6 accepted at t=0, then a read with Lr=5 offered at t=1 → `cmd_ready`=0 at t=1 and t=2; the read is accepted at t=3.
- **FIFO full and timeout.**
  - Issue 8 reads with no return → the 9th read has `cmd_ready`=0 while a write is still accepted.
  - With cfg_rd_timeout=20 → 8 error responses in FIFO-head order, each with `rsp_error`=1.
- **Underrun and spurious.**
  - `wbuf_valid`=0 in a write slot → `dp_wstrb`=0 and `err_underrun`=1.
  - `rd_valid_any` with the FIFO empty → no `rsp_valid` and `err_spurious`=1.
- **Reset mid-burst.** Assert `rst_n`=0 between two beats → all outputs are at their reset values in the same cycle, and a new command is accepted after release.

Source files
------------

// File: rtl/openddr_dfi_data_sched_if.sv
// Command, write-buffer, datapath and read-response signals of the DFI data scheduler.
// The scheduler uses the slave view; the command/datapath side uses the master view.
interface openddr_dfi_data_sched_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic                      cmd_write;
   logic [ID_WIDTH-1:0]       cmd_id;
   logic [4:0]                cfg_wrlat;
   logic [4:0]                cfg_rdlat;
   logic [7:0]                cfg_rd_timeout;
   logic                      wbuf_valid;
   logic                      wbuf_ready;
   logic [DATA_WIDTH-1:0]     wbuf_data;
   logic [DATA_WIDTH/8-1:0]   wbuf_strb;
   logic [DATA_WIDTH-1:0]     dp_wdata;
   logic [DATA_WIDTH/8-1:0]   dp_wstrb;
   logic                      dfi_rddata_en;
   logic                      rd_valid_any;
   logic [DATA_WIDTH-1:0]     dp_rdata;
   logic                      rsp_valid;
   logic [ID_WIDTH-1:0]       rsp_id;
   logic [DATA_WIDTH-1:0]     rsp_data;
   logic                      rsp_last;
   logic                      rsp_error;
   logic                      busy;
   logic                      err_underrun;
   logic                      err_spurious;

   modport master (
      output cmd_valid, cmd_write, cmd_id, cfg_wrlat, cfg_rdlat, cfg_rd_timeout,
             wbuf_valid, wbuf_data, wbuf_strb, rd_valid_any, dp_rdata,
      input  cmd_ready, wbuf_ready, dp_wdata, dp_wstrb, dfi_rddata_en,
             rsp_valid, rsp_id, rsp_data, rsp_last, rsp_error,
             busy, err_underrun, err_spurious
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_id, cfg_wrlat, cfg_rdlat, cfg_rd_timeout,
             wbuf_valid, wbuf_data, wbuf_strb, rd_valid_any, dp_rdata,
      output cmd_ready, wbuf_ready, dp_wdata, dp_wstrb, dfi_rddata_en,
             rsp_valid, rsp_id, rsp_data, rsp_last, rsp_error,
             busy, err_underrun, err_spurious
   );
endinterface

// File: rtl/openddr_dfi_data_sched.sv
// DFI data-timing scheduler: reserves data-bus slots for column commands, streams
// write beats into the datapath and returns in-order tagged (or timed-out) read responses.
module openddr_dfi_data_sched #(
   parameter int DATA_WIDTH   = 64,
   parameter int ID_WIDTH     = 4,
   parameter int MAX_LAT      = 31,
   parameter int BURST_CYCLES = 2,
   parameter int RD_DEPTH     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   openddr_dfi_data_sched_if.slave bus
);
   localparam int MAP_W  = MAX_LAT + BURST_CYCLES;
   localparam int PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
   localparam logic [MAP_W-1:0]  BURST_ONES = MAP_W'((64'd1 << BURST_CYCLES) - 64'd1);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(RD_DEPTH);

   function automatic logic [4:0] clamp_lat(input logic [4:0] cfg);
      if (cfg == 5'd0) return 5'd1;
      if (int'(cfg) > MAX_LAT) return 5'(MAX_LAT);
      return cfg;
   endfunction

   // Bit k of a map means "bus slot in use k cycles from now"; bit 0 is the current cycle.
   logic [MAP_W-1:0]    r_wr_map;
   logic [MAP_W-1:0]    r_rd_map;
   logic [ID_WIDTH-1:0] r_fifo [RD_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [BEAT_W-1:0]   r_beat;
   logic [7:0]          r_timer;
   logic                r_rsp_valid;
   logic [ID_WIDTH-1:0] r_rsp_id;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                r_rsp_last;
   logic                r_rsp_error;
   logic                r_err_underrun;
   logic                r_err_spurious;

   logic [4:0]          w_lat;
   logic [MAP_W-1:0]    w_win;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_slot_free;
   logic                w_cmd_ready;
   logic                w_accept;
   logic                w_push;
   logic                w_valid_hit;
   logic                w_last_beat;
   logic                w_timeout;
   logic                w_pop;
   logic                w_beat_ok;
   logic [ID_WIDTH-1:0] w_head;

   assign w_lat        = bus.cmd_write ? clamp_lat(bus.cfg_wrlat) : clamp_lat(bus.cfg_rdlat);
   assign w_win        = BURST_ONES << w_lat;
   assign w_fifo_full  = (r_count == FULL_CNT);
   assign w_fifo_empty = (r_count == '0);
   assign w_slot_free  = ((r_wr_map | r_rd_map) & w_win) == '0;
   assign w_cmd_ready  = w_slot_free && (bus.cmd_write || !w_fifo_full);
   assign w_accept     = bus.cmd_valid && w_cmd_ready;
   assign w_push       = w_accept && !bus.cmd_write;
   assign w_head       = r_fifo[r_rd_ptr];

   // A real valid always beats a coincident timeout, so the two are mutually exclusive.
   assign w_valid_hit  = bus.rd_valid_any && !w_fifo_empty;
   assign w_last_beat  = w_valid_hit && (r_beat == LAST_BEAT);
   assign w_timeout    = !w_fifo_empty && !bus.rd_valid_any &&
                         (bus.cfg_rd_timeout != 8'd0) && (r_timer == bus.cfg_rd_timeout);
   assign w_pop        = w_last_beat || w_timeout;
   assign w_beat_ok    = r_wr_map[0] && bus.wbuf_valid;

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= bus.cmd_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_map       <= '0;
         r_rd_map       <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_beat         <= '0;
         r_timer        <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_id       <= '0;
         r_rsp_data     <= '0;
         r_rsp_last     <= 1'b0;
         r_rsp_error    <= 1'b0;
         r_err_underrun <= 1'b0;
         r_err_spurious <= 1'b0;
      end else begin
         // The window is set one bit lower because the map shifts in the same edge.
         r_wr_map <= (r_wr_map >> 1) | ((w_accept && bus.cmd_write) ? (w_win >> 1) : '0);
         r_rd_map <= (r_rd_map >> 1) | (w_push ? (w_win >> 1) : '0);

         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);

         if (w_pop)            r_beat <= '0;
         else if (w_valid_hit) r_beat <= r_beat + BEAT_W'(1);

         if (w_pop || bus.rd_valid_any || w_fifo_empty) r_timer <= '0;
         else                                           r_timer <= r_timer + 8'd1;

         r_rsp_valid <= w_valid_hit || w_timeout;
         r_rsp_last  <= w_last_beat || w_timeout;
         r_rsp_error <= w_timeout;
         if (w_valid_hit || w_timeout) begin
            r_rsp_id   <= w_head;
            r_rsp_data <= w_valid_hit ? bus.dp_rdata : '0;
         end

         if (r_wr_map[0] && !bus.wbuf_valid)  r_err_underrun <= 1'b1;
         if (bus.rd_valid_any && w_fifo_empty) r_err_spurious <= 1'b1;
      end
   end

   assign bus.cmd_ready     = w_cmd_ready;
   assign bus.wbuf_ready    = r_wr_map[0];
   assign bus.dp_wdata      = w_beat_ok ? bus.wbuf_data : '0;
   assign bus.dp_wstrb      = w_beat_ok ? bus.wbuf_strb : '0;
   assign bus.dfi_rddata_en = r_rd_map[0];
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_id        = r_rsp_id;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.rsp_last      = r_rsp_last;
   assign bus.rsp_error     = r_rsp_error;
   assign bus.busy          = (|r_wr_map) || (|r_rd_map) || !w_fifo_empty;
   assign bus.err_underrun  = r_err_underrun;
   assign bus.err_spurious  = r_err_spurious;
endmodule

// File: tb/tb_openddr_dfi_data_sched.sv
// Directed self-checking bench for openddr_dfi_data_sched; inputs change 1 time unit
// after a rising edge and outputs are sampled on the falling edge.
module tb_openddr_dfi_data_sched;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_asserts = 0;
   int   n_fail    = 0;

   openddr_dfi_data_sched_if #(.DATA_WIDTH(64), .ID_WIDTH(4)) bus ();

   openddr_dfi_data_sched #(
      .DATA_WIDTH(64), .ID_WIDTH(4), .MAX_LAT(31), .BURST_CYCLES(2), .RD_DEPTH(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         mid();
         if (bus.rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         nxt();
      end
   endtask

   initial begin
      bit         ok;
      logic [3:0] exp_id;

      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_id = 4'd0;
      bus.cfg_wrlat = 5'd5; bus.cfg_rdlat = 5'd4; bus.cfg_rd_timeout = 8'd0;
      bus.wbuf_valid = 1'b0; bus.wbuf_data = '0; bus.wbuf_strb = '0;
      bus.rd_valid_any = 1'b0; bus.dp_rdata = '0;

      // reset state
      repeat (2) nxt();
      mid();
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_wbuf_ready", bus.wbuf_ready, 0);
      chk("rst_dp_wstrb", bus.dp_wstrb, 0);
      chk("rst_rddata_en", bus.dfi_rddata_en, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err_underrun", bus.err_underrun, 0);
      nxt();
      rst_n = 1'b1; bus.cmd_valid = 1'b0;
      nxt();

      // single write, Lw=5, strobes 0xFF
      bus.wbuf_valid = 1'b1; bus.wbuf_strb = 8'hFF; bus.wbuf_data = 64'hA5A5_0000_5A5A_FFFF;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_id = 4'd1;
      mid();
      chk("wr_cmd_ready", bus.cmd_ready, 1);
      nxt();
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         mid();
         if (c == 1) chk("wr_busy", bus.busy, 1);
         chk("wr_wbuf_ready", bus.wbuf_ready, (c == 5 || c == 6));
         chk("wr_dp_wstrb", bus.dp_wstrb, (c == 5 || c == 6) ? 8'hFF : 8'h00);
         chk("wr_dp_wdata", bus.dp_wdata, (c == 5 || c == 6) ? 64'hA5A5_0000_5A5A_FFFF : 64'h0);
         nxt();
      end
      $display("write id=1 done");

      // single read, id=3, Lr=4, PHY returns at +9/+10
      bus.cfg_rdlat = 5'd4;
      for (int c = 0; c <= 12; c++) begin
         bus.cmd_valid = (c == 0); bus.cmd_write = 1'b0; bus.cmd_id = 4'd3;
         bus.rd_valid_any = (c == 9 || c == 10);
         bus.dp_rdata = (c == 9) ? 64'h1111_2222_3333_4444 : 64'h5555_6666_7777_8888;
         mid();
         if (c == 0) chk("rd_cmd_ready", bus.cmd_ready, 1);
         chk("rd_rddata_en", bus.dfi_rddata_en, (c == 4 || c == 5));
         chk("rd_rsp_valid", bus.rsp_valid, (c == 10 || c == 11));
         chk("rd_rsp_last", bus.rsp_last, (c == 11));
         if (c == 10) begin
            chk("rd_rsp_data0", bus.rsp_data, 64'h1111_2222_3333_4444);
            chk("rd_rsp_id0", bus.rsp_id, 4'd3);
         end
         if (c == 11) begin
            chk("rd_rsp_data1", bus.rsp_data, 64'h5555_6666_7777_8888);
            chk("rd_rsp_id1", bus.rsp_id, 4'd3);
            chk("rd_rsp_error", bus.rsp_error, 0);
         end
         nxt();
      end
      mid();
      chk("rd_busy_idle", bus.busy, 0);
      $display("read id=3 done");
      nxt();

      // write Lw=6 then read Lr=5 collides for two cycles
      bus.cfg_wrlat = 5'd6; bus.cfg_rdlat = 5'd5; bus.cmd_id = 4'd5;
      for (int c = 0; c <= 13; c++) begin
         bus.cmd_valid = (c <= 3); bus.cmd_write = (c == 0);
         bus.rd_valid_any = (c == 10 || c == 11);
         bus.dp_rdata = 64'(c);
         mid();
         if (c <= 3) chk("cf_cmd_ready", bus.cmd_ready, (c == 0 || c == 3));
         chk("cf_wbuf_ready", bus.wbuf_ready, (c == 6 || c == 7));
         chk("cf_rddata_en", bus.dfi_rddata_en, (c == 8 || c == 9));
         if (c == 11) begin
            chk("cf_rsp_id", bus.rsp_id, 4'd5);
            chk("cf_rsp_data", bus.rsp_data, 64'd10);
            chk("cf_rsp_last0", bus.rsp_last, 0);
         end
         if (c == 12) chk("cf_rsp_last1", bus.rsp_last, 1);
         nxt();
      end
      $display("conflict write/read id=5 done");

      // fill the read-ID FIFO with 8 reads that never return
      bus.cfg_rdlat = 5'd1; bus.cmd_write = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.cmd_valid = 1'b1; bus.cmd_id = 4'(i * 3 + 1);
         mid();
         chk("fill_cmd_ready", bus.cmd_ready, 1);
         nxt();
         bus.cmd_valid = 1'b0;
         nxt();
      end
      bus.cmd_valid = 1'b1; bus.cmd_id = 4'd9;
      mid();
      chk("full_rd_blocked", bus.cmd_ready, 0);
      chk("full_busy", bus.busy, 1);
      nxt();
      bus.cmd_write = 1'b1;
      mid();
      chk("full_wr_accepted", bus.cmd_ready, 1);
      nxt();
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cfg_rd_timeout = 8'd20;
      for (int i = 0; i < 8; i++) begin
         wait_rsp(ok);
         exp_id = 4'(i * 3 + 1);
         chk("to_rsp_seen", ok, 1);
         chk("to_rsp_id", bus.rsp_id, exp_id);
         chk("to_rsp_error", bus.rsp_error, 1);
         chk("to_rsp_last", bus.rsp_last, 1);
         chk("to_rsp_data", bus.rsp_data, 64'h0);
         $display("timeout response %0d id=%0d error=%0b", i, bus.rsp_id, bus.rsp_error);
         nxt();
      end
      repeat (3) nxt();
      mid();
      chk("to_busy_clear", bus.busy, 0);
      chk("to_no_spurious", bus.err_spurious, 0);
      nxt();

      // write slot with no data available
      bus.cfg_rd_timeout = 8'd0; bus.cfg_wrlat = 5'd2; bus.wbuf_valid = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      mid();
      chk("ur_cmd_ready", bus.cmd_ready, 1);
      chk("ur_flag_before", bus.err_underrun, 0);
      nxt();
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         mid();
         chk("ur_wbuf_ready", bus.wbuf_ready, (c >= 2));
         chk("ur_dp_wstrb", bus.dp_wstrb, 0);
         chk("ur_err_underrun", bus.err_underrun, (c == 3));
         nxt();
      end
      $display("underrun write done");

      // read valid with nothing outstanding
      bus.rd_valid_any = 1'b1;
      mid();
      chk("sp_flag_before", bus.err_spurious, 0);
      nxt();
      bus.rd_valid_any = 1'b0;
      mid();
      chk("sp_no_rsp", bus.rsp_valid, 0);
      chk("sp_err_spurious", bus.err_spurious, 1);
      $display("spurious valid done");
      nxt();

      // reset between the two beats of a write burst
      bus.cfg_wrlat = 5'd3; bus.wbuf_valid = 1'b1; bus.wbuf_strb = 8'h0F;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      nxt();
      bus.cmd_valid = 1'b0;
      nxt();
      nxt();
      mid();
      chk("rb_beat0_ready", bus.wbuf_ready, 1);
      chk("rb_beat0_strb", bus.dp_wstrb, 8'h0F);
      rst_n = 1'b0; bus.cmd_valid = 1'b1;
      #1;
      chk("rb_wbuf_ready", bus.wbuf_ready, 0);
      chk("rb_dp_wstrb", bus.dp_wstrb, 0);
      chk("rb_dp_wdata", bus.dp_wdata, 0);
      chk("rb_rddata_en", bus.dfi_rddata_en, 0);
      chk("rb_rsp_valid", bus.rsp_valid, 0);
      chk("rb_rsp_id", bus.rsp_id, 0);
      chk("rb_rsp_data", bus.rsp_data, 0);
      chk("rb_rsp_last", bus.rsp_last, 0);
      chk("rb_rsp_error", bus.rsp_error, 0);
      chk("rb_busy", bus.busy, 0);
      chk("rb_err_underrun", bus.err_underrun, 0);
      chk("rb_err_spurious", bus.err_spurious, 0);
      chk("rb_cmd_ready", bus.cmd_ready, 1);
      nxt();
      mid();
      chk("rb_beat1_dropped", bus.wbuf_ready, 0);
      nxt();
      rst_n = 1'b1; bus.cmd_write = 1'b0; bus.cmd_id = 4'd7; bus.cfg_rdlat = 5'd2;
      mid();
      chk("rb_new_cmd_ready", bus.cmd_ready, 1);
      nxt();
      bus.cmd_valid = 1'b0;
      nxt();
      mid();
      chk("rb_new_rddata_en", bus.dfi_rddata_en, 1);
      chk("rb_new_busy", bus.busy, 1);
      $display("reset mid-burst and new read id=7 done");
      nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
